// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// icache_refill_ctrl : set-associative I-cache lookup, miss refill and flush
// Rev 1.0
// ============================================================================
module icache_refill_ctrl #(
   parameter  int ADDR_WIDTH = 4,
   parameter  int N_WAY      = 4,
   parameter  int TAG_WIDTH  = 11,
   localparam int DATA_WIDTH = 1 + TAG_WIDTH + 32
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_req_valid,
   input  logic [31:0]                 i_req_addr,
   output logic                        o_req_ready,
   output logic                        o_resp_valid,
   output logic [31:0]                 o_resp_instr,
   input  logic                        i_flush,
   output logic                        o_busy,
   output logic [ADDR_WIDTH-1:0]       o_rf_read_addr,
   input  logic [N_WAY*DATA_WIDTH-1:0] i_rf_read_data,
   output logic [N_WAY-1:0]            o_rf_we,
   output logic [ADDR_WIDTH-1:0]       o_rf_waddr,
   output logic [DATA_WIDTH-1:0]       o_rf_wdata,
   output logic                        o_mem_req,
   output logic [31:0]                 o_mem_addr,
   input  logic                        i_mem_gnt,
   input  logic                        i_mem_rvalid,
   input  logic [31:0]                 i_mem_rdata,
   output logic [15:0]                 o_hit_cnt,
   output logic [15:0]                 o_miss_cnt
);

   localparam int SETS  = 2**ADDR_WIDTH;
   localparam int WAY_W = $clog2(N_WAY);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MISS_REQ  = 3'd1,
      ST_MISS_WAIT = 3'd2,
      ST_REFILL    = 3'd3,
      ST_FLUSH     = 3'd4
   } state_e;

   state_e                       state_q, state_d;
   logic                         s1_valid_q, s1_valid_d;
   logic [29:0]                  s1_addr_q, s1_addr_d;   // word address
   logic                         flush_pending_q, flush_pending_d;
   logic [ADDR_WIDTH-1:0]        flush_cnt_q, flush_cnt_d;
   logic [31:0]                  rdata_q, rdata_d;
   logic [SETS-1:0][WAY_W-1:0]   rr_q, rr_d;
   logic [15:0]                  hit_cnt_q, hit_cnt_d;
   logic [15:0]                  miss_cnt_q, miss_cnt_d;

   logic [ADDR_WIDTH-1:0]        s1_idx;
   logic [TAG_WIDTH-1:0]         s1_tag;
   logic [N_WAY-1:0]             way_valid, way_match;
   logic [N_WAY-1:0][31:0]       way_instr;
   logic                         hit, miss, has_free, accept;
   logic [31:0]                  hit_instr;
   logic [WAY_W-1:0]             free_way, victim;
   logic                         unused_addr_bits;

   assign s1_idx           = s1_addr_q[ADDR_WIDTH-1:0];
   assign s1_tag           = s1_addr_q[TAG_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
   assign unused_addr_bits = ^i_req_addr[1:0];

   for (genvar w = 0; w < N_WAY; w++) begin : g_way
      logic [DATA_WIDTH-1:0] entry;
      assign entry        = i_rf_read_data[w*DATA_WIDTH +: DATA_WIDTH];
      assign way_valid[w] = entry[DATA_WIDTH-1];
      assign way_match[w] = entry[DATA_WIDTH-1] && (entry[DATA_WIDTH-2 -: TAG_WIDTH] == s1_tag);
      assign way_instr[w] = entry[31:0];
   end

   // Descending scans so the lowest-index way takes priority.
   always_comb begin
      hit       = 1'b0;
      hit_instr = '0;
      has_free  = 1'b0;
      free_way  = '0;
      for (int w = N_WAY-1; w >= 0; w--) begin
         if (way_match[w]) begin
            hit       = 1'b1;
            hit_instr = way_instr[w];
         end
         if (!way_valid[w]) begin
            has_free = 1'b1;
            free_way = WAY_W'(w);
         end
      end
      victim = has_free ? free_way : rr_q[s1_idx];
   end

   assign miss        = s1_valid_q & ~hit;
   assign o_req_ready = (state_q == ST_IDLE) & ~flush_pending_q & ~i_flush & ~miss;
   assign accept      = i_req_valid & o_req_ready;

   always_comb begin
      state_d         = state_q;
      s1_valid_d      = s1_valid_q;
      s1_addr_d       = s1_addr_q;
      flush_pending_d = flush_pending_q | i_flush;
      flush_cnt_d     = flush_cnt_q;
      rdata_d         = rdata_q;
      rr_d            = rr_q;
      hit_cnt_d       = hit_cnt_q;
      miss_cnt_d      = miss_cnt_q;
      o_resp_valid    = 1'b0;
      o_resp_instr    = '0;
      o_mem_req       = 1'b0;
      o_rf_we         = '0;
      o_rf_waddr      = '0;
      o_rf_wdata      = '0;

      case (state_q)
         ST_IDLE: begin
            if (s1_valid_q && hit) begin
               o_resp_valid = 1'b1;
               o_resp_instr = hit_instr;
               hit_cnt_d    = hit_cnt_q + 16'd1;
            end
            if (miss) begin
               state_d    = ST_MISS_REQ;
               miss_cnt_d = miss_cnt_q + 16'd1;
            end else begin
               s1_valid_d = accept;
               if (accept) s1_addr_d = i_req_addr[31:2];
               if (flush_pending_q) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = '0;
               end
            end
         end
         ST_MISS_REQ: begin
            o_mem_req = 1'b1;
            if (i_mem_gnt) state_d = ST_MISS_WAIT;
         end
         ST_MISS_WAIT: begin
            if (i_mem_rvalid) begin
               rdata_d = i_mem_rdata;
               state_d = ST_REFILL;
            end
         end
         ST_REFILL: begin
            o_rf_we      = N_WAY'(1) << victim;
            o_rf_waddr   = s1_idx;
            o_rf_wdata   = {1'b1, s1_tag, rdata_q};
            o_resp_valid = 1'b1;
            o_resp_instr = rdata_q;
            s1_valid_d   = 1'b0;
            state_d      = ST_IDLE;
            // Pointer only advances when it actually chose the victim.
            if (!has_free) rr_d[s1_idx] = rr_q[s1_idx] + 1'b1;
         end
         ST_FLUSH: begin
            o_rf_we     = '1;
            o_rf_waddr  = flush_cnt_q;
            rr_d        = '0;
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (&flush_cnt_q) begin
               flush_pending_d = i_flush;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q         <= ST_IDLE;
         s1_valid_q      <= 1'b0;
         s1_addr_q       <= '0;
         flush_pending_q <= 1'b0;
         flush_cnt_q     <= '0;
         rdata_q         <= '0;
         rr_q            <= '0;
         hit_cnt_q       <= '0;
         miss_cnt_q      <= '0;
      end else begin
         state_q         <= state_d;
         s1_valid_q      <= s1_valid_d;
         s1_addr_q       <= s1_addr_d;
         flush_pending_q <= flush_pending_d;
         flush_cnt_q     <= flush_cnt_d;
         rdata_q         <= rdata_d;
         rr_q            <= rr_d;
         hit_cnt_q       <= hit_cnt_d;
         miss_cnt_q      <= miss_cnt_d;
      end
   end

   assign o_busy         = (state_q != ST_IDLE) | flush_pending_q;
   assign o_rf_read_addr = s1_idx;
   assign o_mem_addr     = {s1_addr_q, 2'b00};
   assign o_hit_cnt      = hit_cnt_q;
   assign o_miss_cnt     = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_icache_refill_ctrl : directed + randomized bench against a cache model
// Rev 1.0
// ============================================================================
module tb_icache_refill_ctrl;

   localparam int AW   = 4;
   localparam int NW   = 4;
   localparam int TW   = 11;
   localparam int DW   = 1 + TW + 32;
   localparam int SETS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_req_valid = 1'b0, i_flush = 1'b0;
   logic [31:0]   i_req_addr = '0, i_mem_rdata = '0;
   logic          i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
   logic          o_req_ready, o_resp_valid, o_busy, o_mem_req;
   logic [31:0]   o_resp_instr, o_mem_addr;
   logic [AW-1:0] o_rf_read_addr, o_rf_waddr;
   logic [NW*DW-1:0] rf_rdata;
   logic [NW-1:0] o_rf_we;
   logic [DW-1:0] o_rf_wdata;
   logic [15:0]   o_hit_cnt, o_miss_cnt;

   always #5 clk = ~clk;

   icache_refill_ctrl #(.ADDR_WIDTH(AW), .N_WAY(NW), .TAG_WIDTH(TW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .o_req_ready(o_req_ready),
      .o_resp_valid(o_resp_valid), .o_resp_instr(o_resp_instr),
      .i_flush(i_flush), .o_busy(o_busy),
      .o_rf_read_addr(o_rf_read_addr), .i_rf_read_data(rf_rdata),
      .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
      .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
   );

   // Storage array the controller drives: combinational read, clocked write.
   logic          tb_clear = 1'b1;
   logic [DW-1:0] rf [SETS][NW];
   for (genvar w = 0; w < NW; w++) begin : g_rd
      assign rf_rdata[w*DW +: DW] = rf[o_rf_read_addr][w];
   end
   always @(posedge clk) begin
      if (tb_clear) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < NW; w++) rf[s][w] <= '0;
      end else begin
         for (int w = 0; w < NW; w++)
            if (o_rf_we[w]) rf[o_rf_waddr][w] <= o_rf_wdata;
      end
   end

   // Reference cache contents, kept independently of the array above.
   bit            mv  [SETS][NW];
   logic [TW-1:0] mt  [SETS][NW];
   logic [31:0]   md  [SETS][NW];
   int            mrr [SETS];
   logic [15:0]   m_hits = '0, m_misses = '0;
   int            n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int m_lookup(input logic [31:0] a);
      int s;
      logic [TW-1:0] t;
      s = int'(a[AW+1:2]);
      t = a[TW+AW+1:AW+2];
      for (int w = 0; w < NW; w++)
         if (mv[s][w] && mt[s][w] == t) return w;
      return -1;
   endfunction

   function automatic void m_clear();
      for (int s = 0; s < SETS; s++) begin
         mrr[s] = 0;
         for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
      end
   endfunction

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_ctl"}, {o_resp_valid, o_mem_req, o_busy, o_req_ready, o_rf_we}, {4'b0001, 4'h0});
      check_eq({tag, "_cnt"}, {o_hit_cnt, o_miss_cnt}, 0);
      check_eq({tag, "_addr"}, {o_mem_addr, o_rf_read_addr, o_rf_waddr}, 0);
      check_eq({tag, "_data"}, {o_resp_instr, o_rf_wdata}, 0);
   endtask

   // Called at the negedge where the controller is idle with a flush pending.
   task automatic expect_flush();
      check_eq("flush_pending", {o_busy, o_req_ready, o_rf_we}, {2'b10, 4'h0});
      @(negedge clk);
      for (int k = 0; k < SETS; k++) begin
         check_eq("flush_we", o_rf_we, {NW{1'b1}});
         check_eq("flush_wdata", o_rf_wdata, 0);
         check_eq("flush_waddr", o_rf_waddr, k);
         check_eq("flush_busy_ready", {o_busy, o_req_ready, o_resp_valid}, 3'b100);
         @(negedge clk);
      end
      check_eq("post_flush", {o_busy, o_req_ready}, 2'b01);
      m_clear();
   endtask

   // mode 0: plain fetch, 1: flush pulse during the memory wait, 2: reset during the wait
   task automatic fetch(input logic [31:0] a, input int gdly, input int rdly,
                        input logic [31:0] data, input int mode);
      int s, w, v;
      logic [TW-1:0] t;
      bit full;
      s = int'(a[AW+1:2]);
      t = a[TW+AW+1:AW+2];
      w = m_lookup(a);
      check_eq("ready_idle", o_req_ready, 1);
      i_req_valid = 1'b1;
      i_req_addr  = a;
      @(negedge clk);
      i_req_valid = 1'b0;
      i_req_addr  = $urandom;
      if (w >= 0) begin
         m_hits++;
         check_eq("hit_resp", {o_resp_valid, o_resp_instr}, {1'b1, md[s][w]});
         @(negedge clk);
         check_eq("hit_cnt", o_hit_cnt, m_hits);
         return;
      end
      check_eq("miss_detect", {o_resp_valid, o_req_ready}, 2'b00);
      m_misses++;
      @(negedge clk);
      check_eq("miss_cnt", o_miss_cnt, m_misses);
      for (int k = 0; k <= gdly; k++) begin
         check_eq("mem_req", {o_mem_req, o_busy, o_req_ready, o_resp_valid}, 4'b1100);
         check_eq("mem_addr", o_mem_addr, {a[31:2], 2'b00});
         i_mem_gnt = (k == gdly);
         @(negedge clk);
      end
      i_mem_gnt = 1'b0;
      for (int j = 1; j <= rdly; j++) begin
         check_eq("mem_wait", {o_mem_req, o_busy, o_req_ready, o_resp_valid}, 4'b0100);
         if (mode == 2) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outs("async_rst");
            m_hits = '0;
            m_misses = '0;
            for (int q = 0; q < SETS; q++) mrr[q] = 0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (mode == 1 && j == 1) i_flush = 1'b1;
         i_mem_rvalid = (j == rdly);
         i_mem_rdata  = (j == rdly) ? data : $urandom;
         @(negedge clk);
         i_flush = 1'b0;
      end
      i_mem_rvalid = 1'b0;
      full = 1'b1;
      v    = -1;
      for (int q = NW-1; q >= 0; q--)
         if (!mv[s][q]) begin
            full = 1'b0;
            v    = q;
         end
      if (full) v = mrr[s];
      check_eq("refill_resp", {o_resp_valid, o_resp_instr}, {1'b1, data});
      check_eq("refill_we", o_rf_we, NW'(1) << v);
      check_eq("refill_waddr", o_rf_waddr, s);
      check_eq("refill_wdata", o_rf_wdata, {1'b1, t, data});
      mv[s][v] = 1'b1;
      mt[s][v] = t;
      md[s][v] = data;
      if (full) mrr[s] = (mrr[s] + 1) % NW;
      @(negedge clk);
      if (mode == 1) expect_flush();
      else check_eq("ready_after_refill", o_req_ready, 1);
   endtask

   task automatic hit_burst(input logic [31:0] a, input int n);
      int s, w;
      logic [15:0] base;
      s = int'(a[AW+1:2]);
      w = m_lookup(a);
      if (w < 0) return;
      base = m_hits;
      i_req_valid = 1'b1;
      i_req_addr  = a;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (k == n) i_req_valid = 1'b0;
         check_eq("burst_resp", {o_resp_valid, o_req_ready, o_resp_instr}, {2'b11, md[s][w]});
         check_eq("burst_hit_cnt", o_hit_cnt, base + 16'(k - 1));
      end
      @(negedge clk);
      m_hits = base + 16'(n);
      check_eq("burst_end", {o_resp_valid, o_hit_cnt}, {1'b0, m_hits});
   endtask

   logic [31:0] ra;

   initial begin
      m_clear();
      repeat (2) @(negedge clk);
      check_reset_outs("reset");
      rst_n    = 1'b1;
      tb_clear = 1'b0;

      fetch(32'h0000_0040, 0, 1, 32'hDEAD_BEEF, 0);
      hit_burst(32'h0000_0040, 4);

      // Flush and request together: flush wins, request is dropped.
      i_flush     = 1'b1;
      i_req_valid = 1'b1;
      i_req_addr  = 32'h0000_0080;
      #1 check_eq("flush_blocks_ready", o_req_ready, 0);
      @(negedge clk);
      i_flush     = 1'b0;
      i_req_valid = 1'b0;
      check_eq("flush_no_resp", o_resp_valid, 0);
      expect_flush();
      check_eq("flush_counts", {o_hit_cnt, o_miss_cnt}, {m_hits, m_misses});

      for (int k = 0; k < 5; k++)
         fetch(32'(k * 32'h40), k % 2, 1 + k % 3, $urandom, 0);
      fetch(32'h0000_0000, 1, 2, 32'h0BAD_F00D, 0);
      fetch(32'h0000_0000, 0, 1, 32'h0, 0);

      fetch(32'h0000_0040, 1, 3, 32'h1234_5678, 1);
      fetch(32'h0000_0040, 0, 1, 32'hCAFE_0040, 0);
      fetch(32'h8000_0A44, 5, 2, 32'h5A5A_A5A5, 0);

      fetch(32'h0000_02C8, 0, 3, 32'h1111_2222, 2);
      fetch(32'h0000_02C8, 0, 1, 32'h3333_4444, 0);

      for (int n = 0; n < 80; n++) begin
         ra = $urandom;
         ra[AW+1:2]       = AW'($urandom_range(0, 3));
         ra[TW+AW+1:AW+2] = TW'($urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0 && m_lookup(ra) >= 0)
            hit_burst(ra, $urandom_range(2, 4));
         else
            fetch(ra, $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
                  ($urandom_range(0, 9) == 0) ? 1 : 0);
      end
      check_eq("final_counts", {o_hit_cnt, o_miss_cnt}, {m_hits, m_misses});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
